// File: rtl/tm_sr_pkg.sv
// Shared definitions for the TMIIa configuration shift-register engines:
// FSM state encoding and the sequence-index to bit-index mapping.
package tm_sr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_LOAD  = 3'd4,
    ST_DONE  = 3'd5
  } sr_state_e;

  // Position in the parallel word of the seq_idx-th bit on the wire.
  // The same mapping is used for the transmitted and the captured word.
  function automatic int unsigned seq_to_bit(input int unsigned seq_idx,
                                             input int unsigned width,
                                             input bit          msb_first);
    int unsigned bit_idx;
    if (msb_first) begin
      bit_idx = width - 32'd1 - seq_idx;
    end else begin
      bit_idx = seq_idx;
    end
    return bit_idx;
  endfunction

endpackage

// File: rtl/sr_clk_div.sv
// Phase timer for pad-clocked serial blocks: while run is high it counts
// DIV system-clock cycles per phase and flags the last cycle of each phase.
// Dropping run restarts the phase from zero.
module sr_clk_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic phase_last
);

  localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0] PH_ONE = PH_W'(1);

  logic [PH_W-1:0] ph_cnt_r;

  assign phase_last = run && (ph_cnt_r == PH_MAX);

  // Phase cycle counter: wraps on the last cycle, held at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_cnt_r <= {PH_W{1'b0}};
    end else if (!run) begin
      ph_cnt_r <= {PH_W{1'b0}};
    end else if (phase_last) begin
      ph_cnt_r <= {PH_W{1'b0}};
    end else begin
      ph_cnt_r <= ph_cnt_r + PH_ONE;
    end
  end

endmodule

// File: rtl/shiftreg_rw_engine.sv
// Full-duplex read/write engine for the TMIIa configuration shift registers.
// Shifts one word into each of N_CHAIN chains on a shared generated sr_clk,
// capturing every chain's previous contents, then optionally strobes sr_load.
// All pad-facing outputs are registered.
module shiftreg_rw_engine
  import tm_sr_pkg::*;
#(
  parameter int DATA_WIDTH      = 170,
  parameter int CNT_WIDTH       = 8,
  parameter int N_CHAIN         = 1,
  parameter int SHIFT_DIRECTION = 1,
  parameter int DIV             = 4,
  parameter int LOAD_EN         = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [N_CHAIN*DATA_WIDTH-1:0] din,
  output logic [N_CHAIN*DATA_WIDTH-1:0] dout,
  output logic                          dout_valid,
  output logic                          busy,
  output logic                          sr_clk,
  output logic [N_CHAIN-1:0]            sr_din,
  input  logic [N_CHAIN-1:0]            sr_dout,
  output logic                          sr_load
);

  localparam int CW    = CNT_WIDTH + 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_END = CW'(DATA_WIDTH);
  localparam bit MSB_FIRST = (SHIFT_DIRECTION != 0);

  sr_state_e        state_r;
  sr_state_e        state_s;
  logic [CW-1:0]    bit_cnt_r;
  logic [CW-1:0]    bit_cnt_s;
  logic [CW-1:0]    bit_cnt_inc_s;
  logic             run_s;
  logic             phase_last_s;
  logic             accept_s;
  logic             shift_entry_s;
  logic             sample_s;
  logic [IDX_W-1:0] tx_idx_s;
  logic [IDX_W-1:0] rx_idx_s;

  logic busy_s;
  logic sr_clk_s;
  logic sr_load_s;
  logic dout_valid_s;

  logic busy_r;
  logic sr_clk_r;
  logic sr_load_r;
  logic dout_valid_r;

  assign run_s         = (state_r == ST_LOW) || (state_r == ST_HIGH) || (state_r == ST_LOAD);
  assign bit_cnt_inc_s = bit_cnt_r + CNT_ONE;

  sr_clk_div #(
    .DIV (DIV)
  ) u_clk_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run_s),
    .phase_last (phase_last_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort wins over everything except an IDLE start.
  always_comb begin
    state_s = state_r;
    if ((state_r != ST_IDLE) && abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) state_s = ST_SETUP;
          else       state_s = ST_IDLE;
        end
        ST_SETUP: state_s = ST_LOW;
        ST_LOW: begin
          if (phase_last_s) state_s = ST_HIGH;
          else              state_s = ST_LOW;
        end
        ST_HIGH: begin
          if (!phase_last_s) begin
            state_s = ST_HIGH;
          end else if (bit_cnt_inc_s != CNT_END) begin
            state_s = ST_LOW;
          end else if (LOAD_EN != 0) begin
            state_s = ST_LOAD;
          end else begin
            state_s = ST_DONE;
          end
        end
        ST_LOAD: begin
          if (phase_last_s) state_s = ST_DONE;
          else              state_s = ST_LOAD;
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Output/datapath decode: next values of registered outputs and shift controls.
  always_comb begin
    busy_s        = (state_s != ST_IDLE);
    sr_clk_s      = (state_s == ST_HIGH);
    sr_load_s     = (state_s == ST_LOAD);
    dout_valid_s  = (state_s == ST_DONE);
    accept_s      = (state_r == ST_IDLE) && start;
    shift_entry_s = (state_s == ST_LOW) && (state_r != ST_LOW);
    sample_s      = (state_r == ST_LOW) && (state_s == ST_HIGH);
    bit_cnt_s     = bit_cnt_r;
    case (state_r)
      ST_SETUP: bit_cnt_s = {CW{1'b0}};
      ST_HIGH: begin
        if (phase_last_s) bit_cnt_s = bit_cnt_inc_s;
        else              bit_cnt_s = bit_cnt_r;
      end
      default: bit_cnt_s = bit_cnt_r;
    endcase
    tx_idx_s = IDX_W'(seq_to_bit(32'(bit_cnt_s), DATA_WIDTH, MSB_FIRST));
    rx_idx_s = IDX_W'(seq_to_bit(32'(bit_cnt_r), DATA_WIDTH, MSB_FIRST));
  end

  // Registered control outputs and the shared bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      sr_clk_r     <= 1'b0;
      sr_load_r    <= 1'b0;
      dout_valid_r <= 1'b0;
      bit_cnt_r    <= {CW{1'b0}};
    end else begin
      busy_r       <= busy_s;
      sr_clk_r     <= sr_clk_s;
      sr_load_r    <= sr_load_s;
      dout_valid_r <= dout_valid_s;
      bit_cnt_r    <= bit_cnt_s;
    end
  end

  assign busy       = busy_r;
  assign sr_clk     = sr_clk_r;
  assign sr_load    = sr_load_r;
  assign dout_valid = dout_valid_r;

  for (genvar k = 0; k < N_CHAIN; k++) begin : g_chain
    logic [DATA_WIDTH-1:0] tx_r;
    logic [DATA_WIDTH-1:0] rx_r;
    logic [DATA_WIDTH-1:0] dout_r;
    logic                  sr_din_r;

    // Transmit shadow: captured at acceptance so din may change mid-transfer.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tx_r <= {DATA_WIDTH{1'b0}};
      end else if (accept_s) begin
        tx_r <= din[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    // Receive shadow: one bit captured on the last LOW cycle, just before sr_clk rises.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rx_r <= {DATA_WIDTH{1'b0}};
      end else if (accept_s) begin
        rx_r <= {DATA_WIDTH{1'b0}};
      end else if (sample_s) begin
        rx_r[rx_idx_s] <= sr_dout[k];
      end
    end

    // Serial data out: changes only on entry to LOW (the sr_clk fall), zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr_din_r <= 1'b0;
      end else if (state_s == ST_IDLE) begin
        sr_din_r <= 1'b0;
      end else if (shift_entry_s) begin
        sr_din_r <= tx_r[tx_idx_s];
      end
    end

    // Read-back word: published together with dout_valid, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_r <= {DATA_WIDTH{1'b0}};
      end else if (dout_valid_s) begin
        dout_r <= rx_r;
      end
    end

    assign dout[k*DATA_WIDTH +: DATA_WIDTH] = dout_r;
    assign sr_din[k]                        = sr_din_r;
  end

endmodule

// File: tb/tb_shiftreg_rw_engine.sv
// Self-checking bench for shiftreg_rw_engine with 8-bit behavioural chip
// shift-register models. Three instances cover the MSB-first single chain,
// the LSB-first dual chain and the no-load DIV=1 configurations.
module tb_shiftreg_rw_engine;

  localparam int DW     = 8;
  localparam int DIV_A  = 2;
  localparam int LOAD_A = 1;
  localparam int DIV_C  = 1;
  localparam int LOAD_C = 0;
  localparam int LAT_A  = 1 + 1 + 2 * DIV_A * DW + LOAD_A * DIV_A + 1;
  localparam int LAT_C  = 1 + 1 + 2 * DIV_C * DW + LOAD_C * DIV_C + 1;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic        start_a, abort_a, dout_valid_a, busy_a, sr_clk_a, sr_load_a;
  logic [7:0]  din_a, dout_a;
  logic [0:0]  sr_din_a, sr_dout_a;

  logic        start_b, abort_b, dout_valid_b, busy_b, sr_clk_b, sr_load_b;
  logic [15:0] din_b, dout_b;
  logic [1:0]  sr_din_b, sr_dout_b;

  logic        start_c, abort_c, dout_valid_c, busy_c, sr_clk_c, sr_load_c;
  logic [7:0]  din_c, dout_c;
  logic [0:0]  sr_din_c, sr_dout_c;

  shiftreg_rw_engine #(.DATA_WIDTH(DW), .CNT_WIDTH(4), .N_CHAIN(1), .SHIFT_DIRECTION(1),
                       .DIV(DIV_A), .LOAD_EN(LOAD_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .din(din_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .busy(busy_a), .sr_clk(sr_clk_a),
    .sr_din(sr_din_a), .sr_dout(sr_dout_a), .sr_load(sr_load_a));

  shiftreg_rw_engine #(.DATA_WIDTH(DW), .CNT_WIDTH(4), .N_CHAIN(2), .SHIFT_DIRECTION(0),
                       .DIV(DIV_A), .LOAD_EN(LOAD_A)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .din(din_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .busy(busy_b), .sr_clk(sr_clk_b),
    .sr_din(sr_din_b), .sr_dout(sr_dout_b), .sr_load(sr_load_b));

  shiftreg_rw_engine #(.DATA_WIDTH(DW), .CNT_WIDTH(4), .N_CHAIN(1), .SHIFT_DIRECTION(1),
                       .DIV(DIV_C), .LOAD_EN(LOAD_C)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .din(din_c),
    .dout(dout_c), .dout_valid(dout_valid_c), .busy(busy_c), .sr_clk(sr_clk_c),
    .sr_din(sr_din_c), .sr_dout(sr_dout_c), .sr_load(sr_load_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chip models: MSB-first chains shift left and present bit 7, LSB-first
  // chains shift right and present bit 0. Each shifts once per sr_clk rise.
  logic [7:0] m_a, m_b0, m_b1, m_c;
  logic [7:0] pre_a, pre_b0, pre_b1, pre_c;
  logic       pre_en;
  logic       clk_a_d, clk_b_d, clk_c_d;

  assign sr_dout_a = m_a[7];
  assign sr_dout_b = {m_b1[0], m_b0[0]};
  assign sr_dout_c = m_c[7];

  always @(posedge clk) begin
    clk_a_d <= sr_clk_a;
    clk_b_d <= sr_clk_b;
    clk_c_d <= sr_clk_c;
    if (pre_en) begin
      m_a  <= pre_a;
      m_b0 <= pre_b0;
      m_b1 <= pre_b1;
      m_c  <= pre_c;
    end else begin
      if (sr_clk_a && !clk_a_d) m_a <= {m_a[6:0], sr_din_a[0]};
      if (sr_clk_b && !clk_b_d) begin
        m_b0 <= {sr_din_b[0], m_b0[7:1]};
        m_b1 <= {sr_din_b[1], m_b1[7:1]};
      end
      if (sr_clk_c && !clk_c_d) m_c <= {m_c[6:0], sr_din_c[0]};
    end
  end

  typedef struct {
    logic [7:0] pre;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic [7:0] exp_model;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] c);
    pre_a = a; pre_b0 = b0; pre_b1 = b1; pre_c = c;
    pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  function automatic logic [2:0] probe(input int which);
    case (which)
      0:       return {dout_valid_a, sr_load_a, sr_clk_a};
      1:       return {dout_valid_b, sr_load_b, sr_clk_b};
      default: return {dout_valid_c, sr_load_c, sr_clk_c};
    endcase
  endfunction

  // Issues a one-cycle start (optionally with abort) and follows the transfer
  // up to dout_valid; lat counts the start cycle as 1.
  task automatic run_xfer(input int which, input logic [15:0] dv, input bit ab,
                          output int lat, output int loads, output int highs, output bit ok);
    logic [2:0] p;
    case (which)
      0:       begin din_a = dv[7:0]; start_a = 1'b1; abort_a = ab; end
      1:       begin din_b = dv;      start_b = 1'b1; end
      default: begin din_c = dv[7:0]; start_c = 1'b1; end
    endcase
    lat = 1; loads = 0; highs = 0; ok = 1'b0;
    while (!ok && lat < 300) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; abort_a = 1'b0;
      lat++;
      p = probe(which);
      if (p[1]) loads++;
      if (p[0]) highs++;
      if (p[2]) ok = 1'b1;
    end
  endtask

  int         lat, loads, highs, rises, seen;
  bit         ok;
  logic       prev_clk;
  logic [7:0] dout_prev;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{pre: 8'hA5, din: 8'h3C, exp_dout: 8'hA5, exp_model: 8'h3C};
    vecs[1] = '{pre: 8'h00, din: 8'hFF, exp_dout: 8'h00, exp_model: 8'hFF};
    vecs[2] = '{pre: 8'hFF, din: 8'h00, exp_dout: 8'hFF, exp_model: 8'h00};
    vecs[3] = '{pre: 8'h5A, din: 8'h81, exp_dout: 8'h5A, exp_model: 8'h81};

    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; din_a = 8'h00;
    start_b = 1'b0; abort_b = 1'b0; din_b = 16'h0000;
    start_c = 1'b0; abort_c = 1'b0; din_c = 8'h00;
    pre_en = 1'b0; pre_a = 8'h00; pre_b0 = 8'h00; pre_b1 = 8'h00; pre_c = 8'h00;
    repeat (3) @(negedge clk);

    check("reset_outs_a", {dout_a, dout_valid_a, busy_a, sr_clk_a, sr_din_a, sr_load_a}, 32'h0);
    check("reset_outs_b", {dout_b, dout_valid_b, busy_b, sr_clk_b, sr_din_b, sr_load_b}, 32'h0);
    check("reset_outs_c", {dout_c, dout_valid_c, busy_c, sr_clk_c, sr_din_c, sr_load_c}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven transfers on the MSB-first single chain.
    for (int i = 0; i < 4; i++) begin
      preload(vecs[i].pre, 8'h00, 8'h00, 8'h00);
      run_xfer(0, {8'h00, vecs[i].din}, 1'b0, lat, loads, highs, ok);
      check("a_done",  32'(ok), 32'd1);
      check("a_dout",  32'(dout_a), 32'(vecs[i].exp_dout));
      check("a_model", 32'(m_a), 32'(vecs[i].exp_model));
      check("a_lat",   32'(lat), 32'(LAT_A));
      check("a_load_cycles", 32'(loads), 32'(LOAD_A * DIV_A));
      check("a_clk_high_cycles", 32'(highs), 32'(DIV_A * DW));
      @(negedge clk);
      check("a_valid_pulse", 32'(dout_valid_a), 32'd0);
    end

    // Two LSB-first chains in lock-step.
    preload(8'h00, 8'h01, 8'h80, 8'h00);
    run_xfer(1, {8'hF0, 8'h0F}, 1'b0, lat, loads, highs, ok);
    check("b_done",   32'(ok), 32'd1);
    check("b_dout",   32'(dout_b), 32'h8001);
    check("b_model0", 32'(m_b0), 32'h0F);
    check("b_model1", 32'(m_b1), 32'hF0);
    check("b_lat",    32'(lat), 32'(LAT_A));
    @(negedge clk);

    // Back-to-back with start held; din changes mid-transfer.
    preload(8'h11, 8'h00, 8'h00, 8'h00);
    din_a = 8'h6E; start_a = 1'b1;
    @(negedge clk);
    din_a = 8'hB4;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      if (dout_valid_a) ok = 1'b1;
      else @(negedge clk);
    end
    check("b2b_first_done", 32'(ok), 32'd1);
    check("b2b_first_dout", 32'(dout_a), 32'h11);
    check("b2b_first_model", 32'(m_a), 32'h6E);
    @(negedge clk);
    check("b2b_gap", {30'd0, busy_a, dout_valid_a}, 32'd0);
    @(negedge clk);
    check("b2b_restart_busy", 32'(busy_a), 32'd1);
    start_a = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (dout_valid_a) ok = 1'b1;
    end
    check("b2b_second_done", 32'(ok), 32'd1);
    check("b2b_second_dout", 32'(dout_a), 32'h6E);
    check("b2b_second_model", 32'(m_a), 32'hB4);
    @(negedge clk);

    // Start and abort together in IDLE: the start is taken.
    preload(8'h42, 8'h00, 8'h00, 8'h00);
    run_xfer(0, 16'h0024, 1'b1, lat, loads, highs, ok);
    check("abort_idle_done",  32'(ok), 32'd1);
    check("abort_idle_dout",  32'(dout_a), 32'h42);
    check("abort_idle_model", 32'(m_a), 32'h24);
    check("abort_idle_lat",   32'(lat), 32'(LAT_A));
    @(negedge clk);

    // Abort during the HIGH phase of bit 4.
    preload(8'h99, 8'h00, 8'h00, 8'h00);
    dout_prev = dout_a;
    din_a = 8'h77; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    rises = 0; prev_clk = sr_clk_a;
    for (int n = 0; n < 300 && rises < 5; n++) begin
      @(negedge clk);
      if (sr_clk_a && !prev_clk) rises++;
      prev_clk = sr_clk_a;
    end
    check("abort_reached_bit4", 32'(rises), 32'd5);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("abort_outs", {27'd0, busy_a, sr_clk_a, sr_load_a, sr_din_a, dout_valid_a}, 32'd0);
    check("abort_dout_hold", 32'(dout_a), 32'(dout_prev));
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (dout_valid_a || sr_load_a || busy_a) seen++;
    end
    check("abort_quiet", 32'(seen), 32'd0);

    // Asynchronous reset during the LOW phase of bit 3, then a clean transfer.
    preload(8'hD2, 8'h00, 8'h00, 8'h00);
    din_a = 8'h2D; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    rises = 0; prev_clk = sr_clk_a;
    for (int n = 0; n < 300 && !(rises == 3 && !sr_clk_a); n++) begin
      @(negedge clk);
      if (sr_clk_a && !prev_clk) rises++;
      prev_clk = sr_clk_a;
    end
    check("reset_reached_bit3", {busy_a, 31'(rises)}, {1'b1, 31'd3});
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_outs", {dout_a, dout_valid_a, busy_a, sr_clk_a, sr_din_a, sr_load_a}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    preload(8'hE7, 8'h00, 8'h00, 8'h00);
    run_xfer(0, 16'h0018, 1'b0, lat, loads, highs, ok);
    check("post_reset_done",  32'(ok), 32'd1);
    check("post_reset_dout",  32'(dout_a), 32'hE7);
    check("post_reset_model", 32'(m_a), 32'h18);
    @(negedge clk);

    // No load phase, DIV = 1.
    preload(8'h00, 8'h00, 8'h00, 8'hC3);
    run_xfer(2, 16'h0096, 1'b0, lat, loads, highs, ok);
    check("c_done",  32'(ok), 32'd1);
    check("c_dout",  32'(dout_c), 32'hC3);
    check("c_model", 32'(m_c), 32'h96);
    check("c_lat",   32'(lat), 32'(LAT_C));
    check("c_load_cycles", 32'(loads), 32'd0);
    check("c_clk_high_cycles", 32'(highs), 32'(DIV_C * DW));
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
